// File: rtl/seq_det_pkg.sv
// Shared constants and debug types for the serial pattern detector.
package seq_det_pkg;

  localparam int unsigned SEQ_LEN_DEF = 4;
  localparam logic [SEQ_LEN_DEF-1:0] PATTERN_DEF = 4'b1010;
  localparam int unsigned SEQ_LEN_MIN = 2;
  localparam int unsigned SEQ_LEN_MAX = 16;

  // Progress states of the equivalent default "1010" Moore detector
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } seq_state_t;

  // Width of a counter that must hold values 0..max_val
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sequence_detector_history.sv
// Serial history shift register with a saturating fill counter.
// Exposes next-state values so the caller can compare before the edge.
module seq_history
  import seq_det_pkg::*;
#(
  parameter int unsigned SEQ_LEN = SEQ_LEN_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             seq,
  input  logic                             clr,
  output logic [SEQ_LEN-1:0]               next_hist_c,
  output logic [cnt_width(SEQ_LEN)-1:0]    next_fill_c
);

  localparam int unsigned FILL_W = cnt_width(SEQ_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN);

  logic [SEQ_LEN-1:0] hist;
  logic [FILL_W-1:0]  fill;

  // Next-state values: shift in newest bit, count valid bits up to saturation
  always_comb begin
    next_hist_c = {hist[SEQ_LEN-2:0], seq};
    next_fill_c = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
  end

  // History and fill registers; clr restarts counting on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= next_hist_c;
      fill <= clr ? '0 : next_fill_c;
    end
  end

endmodule

// File: rtl/sequence_detector.sv
// Serial bit-pattern detector with a registered one-cycle match flag.
module sequence_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned        SEQ_LEN = SEQ_LEN_DEF,
  parameter logic [SEQ_LEN-1:0] PATTERN = SEQ_LEN'(PATTERN_DEF),
  parameter bit                 OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic seq,
  output logic detected
);

  localparam int unsigned FILL_W = cnt_width(SEQ_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN);

  // Elaboration-time parameter sanity checks
  if (SEQ_LEN < SEQ_LEN_MIN || SEQ_LEN > SEQ_LEN_MAX) begin : g_bad_len
    $error("sequence_detector: SEQ_LEN %0d outside 2..16", SEQ_LEN);
  end
  if ($bits(PATTERN) != SEQ_LEN) begin : g_bad_pat
    $error("sequence_detector: PATTERN width does not match SEQ_LEN");
  end

  logic [SEQ_LEN-1:0] next_hist_c;
  logic [FILL_W-1:0]  next_fill_c;
  logic               match_c;
  logic               clr_c;

  seq_history #(
    .SEQ_LEN (SEQ_LEN)
  ) u_hist (
    .clk         (clk),
    .rst_n       (rst_n),
    .seq         (seq),
    .clr         (clr_c),
    .next_hist_c (next_hist_c),
    .next_fill_c (next_fill_c)
  );

  // Match on the post-edge window; a full fill rules out reset-zero history
  always_comb begin
    match_c = (next_hist_c == PATTERN) && (next_fill_c == FILL_MAX);
    clr_c   = match_c && !OVERLAP;
  end

  // Registered match flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      detected <= 1'b0;
    end else begin
      detected <= match_c;
    end
  end

endmodule

// File: tb/tb_sequence_detector.sv
// Directed bench: three detector configurations driven by a common stream.
module tb_sequence_detector;

  logic clk;
  logic rst_n;
  logic seq;
  logic det_ov;
  logic det_no;
  logic det_z;

  int tests;
  int fails;

  sequence_detector #(.SEQ_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1)) u_ov (
    .clk(clk), .rst_n(rst_n), .seq(seq), .detected(det_ov)
  );

  sequence_detector #(.SEQ_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0)) u_no (
    .clk(clk), .rst_n(rst_n), .seq(seq), .detected(det_no)
  );

  sequence_detector #(.SEQ_LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b1)) u_z (
    .clk(clk), .rst_n(rst_n), .seq(seq), .detected(det_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic eo, input logic en, input logic ez);
    chk({tag, "/ov1010"}, det_ov, eo);
    chk({tag, "/no1010"}, det_no, en);
    chk({tag, "/ov0000"}, det_z, ez);
  endtask

  // Drive one bit, let it be sampled, then check one time unit later
  task automatic step(input string tag, input logic b,
                      input logic eo, input logic en, input logic ez);
    seq = b;
    @(posedge clk);
    #1;
    chk3(tag, eo, en, ez);
  endtask

  // Async reset pulse released between edges
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    seq   = 1'b0;
    #1;
    chk3(tag, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    seq   = 1'b0;
    #1;
    chk3("reset_init", 1'b0, 1'b0, 1'b0);

    // Held in reset while seq toggles: never any match
    for (int i = 0; i < 6; i++) begin
      seq = (i % 2 == 0) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      chk3("reset_hold", 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Basic stream 0,1,0,1,0,0,0,1,0: first 1010 completes at sample 5
    step("basic1", 1'b0, 1'b0, 1'b0, 1'b0);
    step("basic2", 1'b1, 1'b0, 1'b0, 1'b0);
    step("basic3", 1'b0, 1'b0, 1'b0, 1'b0);
    step("basic4", 1'b1, 1'b0, 1'b0, 1'b0);
    step("basic5", 1'b0, 1'b1, 1'b1, 1'b0);
    step("basic6", 1'b0, 1'b0, 1'b0, 1'b0);
    step("basic7", 1'b0, 1'b0, 1'b0, 1'b0);
    step("basic8", 1'b1, 1'b0, 1'b0, 1'b0);
    step("basic9", 1'b0, 1'b0, 1'b0, 1'b0);

    // Overlap 1,0,1,0,1,0,1,0: overlapping hits 4,6,8; non-overlapping 4,8
    do_reset("rst_ovl");
    step("ovl1", 1'b1, 1'b0, 1'b0, 1'b0);
    step("ovl2", 1'b0, 1'b0, 1'b0, 1'b0);
    step("ovl3", 1'b1, 1'b0, 1'b0, 1'b0);
    step("ovl4", 1'b0, 1'b1, 1'b1, 1'b0);
    step("ovl5", 1'b1, 1'b0, 1'b0, 1'b0);
    step("ovl6", 1'b0, 1'b1, 1'b0, 1'b0);
    step("ovl7", 1'b1, 1'b0, 1'b0, 1'b0);
    step("ovl8", 1'b0, 1'b1, 1'b1, 1'b0);

    // Near-miss 1,0,0,1,0,1,1,0,1,0: only the final window matches
    do_reset("rst_near");
    step("near1", 1'b1, 1'b0, 1'b0, 1'b0);
    step("near2", 1'b0, 1'b0, 1'b0, 1'b0);
    step("near3", 1'b0, 1'b0, 1'b0, 1'b0);
    step("near4", 1'b1, 1'b0, 1'b0, 1'b0);
    step("near5", 1'b0, 1'b0, 1'b0, 1'b0);
    step("near6", 1'b1, 1'b0, 1'b0, 1'b0);
    step("near7", 1'b1, 1'b0, 1'b0, 1'b0);
    step("near8", 1'b0, 1'b0, 1'b0, 1'b0);
    step("near9", 1'b1, 1'b0, 1'b0, 1'b0);
    step("near10", 1'b0, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset while detected is high drops it before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    chk3("async_drop", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-sequence reset discards partial 101
    step("mid1", 1'b1, 1'b0, 1'b0, 1'b0);
    step("mid2", 1'b0, 1'b0, 1'b0, 1'b0);
    step("mid3", 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk3("mid_rst", 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    step("mid4", 1'b0, 1'b0, 1'b0, 1'b0);
    step("mid5", 1'b1, 1'b0, 1'b0, 1'b0);
    step("mid6", 1'b0, 1'b0, 1'b0, 1'b0);
    step("mid7", 1'b1, 1'b0, 1'b0, 1'b0);
    step("mid8", 1'b0, 1'b1, 1'b1, 1'b0);

    // All-zero pattern: silent for 3 zeros, then a pulse every cycle
    do_reset("rst_zero");
    step("zero1", 1'b0, 1'b0, 1'b0, 1'b0);
    step("zero2", 1'b0, 1'b0, 1'b0, 1'b0);
    step("zero3", 1'b0, 1'b0, 1'b0, 1'b0);
    step("zero4", 1'b0, 1'b0, 1'b0, 1'b1);
    step("zero5", 1'b0, 1'b0, 1'b0, 1'b1);
    step("zero6", 1'b0, 1'b0, 1'b0, 1'b1);
    step("zero7", 1'b0, 1'b0, 1'b0, 1'b1);
    step("zero8", 1'b1, 1'b0, 1'b0, 1'b0);
    step("zero9", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
